icache_refill_ctrl: RTL and testbench

- Miss-refill sequencer between the instruction cache and its AXI read master port.
- Accepts one line-miss request and issues one AXI read burst for the full cache line.
- Collects the returned beats into a line buffer and presents the assembled line to the cache for one cycle.
- Handles frontend flush mid-refill by draining the in-flight burst and discarding it, without violating AXI handshake rules.

---
 rtl/icache_refill_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Miss-refill sequencer between the instruction cache and its AXI read port.
// Takes one line miss and issues one AXI read burst for the whole line. It
// assembles the returned beats into a line buffer and presents the line to the
// cache for a single cycle. A frontend flush cancels the refill: the burst
// still in flight is drained and discarded, so no AXI handshake is abandoned.
// Optional feature macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN. When it is
// defined, the controller issues a WRAP burst that starts at the missing beat.
module icache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BYTES = 32,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  output logic                    miss_ready,
  input  logic                    flush,
  output logic                    refill_valid,
  output logic [ADDR_WIDTH-1:0]   refill_addr,
  output logic [LINE_BYTES*8-1:0] refill_data,
  output logic                    refill_err,
  output logic                    busy,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [7:0]              ar_len,
  output logic [2:0]              ar_size,
  output logic [1:0]              ar_burst,
  output logic [3:0]              ar_id,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last
);

  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int BEATS      = LINE_W / DATA_WIDTH;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int BEAT_OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RDATA, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [LINE_W-1:0]     r_line;
  logic [CNT_W-1:0]      r_cnt;       // buffer slot for the next beat
  logic [CNT_W-1:0]      r_beat;      // beats received, used for completion
  logic                  r_cancel;    // a flush arrived while the burst was live
  logic                  r_err;       // line saw a bus or protocol error
  logic                  r_done_err;  // line complete but burst still running
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_final;
  logic                  w_flush_pending;
  logic                  w_set_done_err;
  logic [ADDR_WIDTH-1:0] w_line_base;

  assign w_line_base     = {miss_addr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign w_accept        = (r_state == S_IDLE) && miss_req && !flush;
  assign w_beat          = (r_state == S_RDATA) && r_valid;
  assign w_final         = (r_beat == CNT_W'(BEATS - 1));
  assign w_flush_pending = r_cancel || flush;

  assign ar_addr     = r_ar_addr;
  assign ar_len      = 8'(BEATS - 1);
  assign ar_size     = 3'(BEAT_OFF_W);
  assign ar_id       = 4'(AXI_ID);
  assign refill_addr = r_line_addr;
  assign refill_data = r_line;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic [ADDR_WIDTH-1:0] w_beat_base;
  logic [CNT_W-1:0]      w_start_slot;
  assign w_beat_base  = {miss_addr[ADDR_WIDTH-1:BEAT_OFF_W], {BEAT_OFF_W{1'b0}}};
  assign w_start_slot = miss_addr[LINE_OFF_W-1:BEAT_OFF_W];
  assign ar_burst     = 2'b10;
`else
  assign ar_burst     = 2'b01;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the clock edge.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and per-state handshake and refill outputs.
  always_comb begin
    // NOTE: every signal gets a default value first, so no branch can leave
    // a signal unassigned and infer a latch.
    w_next_state   = r_state;
    w_set_done_err = 1'b0;
    miss_ready     = 1'b0;
    busy           = 1'b1;
    ar_valid       = 1'b0;
    r_ready        = 1'b0;
    refill_valid   = 1'b0;
    refill_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        miss_ready = 1'b1;
        busy       = 1'b0;
        if (w_accept) w_next_state = S_AR;
      end
      S_AR: begin
        // ar_valid stays high through a flush; AXI forbids withdrawing it.
        ar_valid = 1'b1;
        if (ar_ready) w_next_state = w_flush_pending ? S_DRAIN : S_RDATA;
      end
      S_RDATA: begin
        r_ready = 1'b1;
        if (flush) begin
          w_next_state = (r_valid && r_last) ? S_IDLE : S_DRAIN;
        end else if (r_valid) begin
          if (r_last) begin
            w_next_state = S_DONE;
          end else if (w_final) begin
            // The line is full but the slave keeps sending beats. Drain them,
            // then report the line with an error.
            w_next_state   = S_DRAIN;
            w_set_done_err = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        r_ready = 1'b1;
        if (r_valid && r_last)
          w_next_state = (r_done_err && !w_flush_pending) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        refill_valid = !flush;
        refill_err   = r_err && !flush;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request capture, beat collection and the error and cancel flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the line buffer is reset together with the control state so
      // that refill_data has a defined value straight out of reset.
      r_line_addr <= '0;
      r_ar_addr   <= '0;
      r_line      <= '0;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_cancel    <= 1'b0;
      r_err       <= 1'b0;
      r_done_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_line_addr <= w_line_base;
        r_beat      <= '0;
        r_cancel    <= 1'b0;
        r_err       <= 1'b0;
        r_done_err  <= 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        r_ar_addr   <= w_beat_base;
        r_cnt       <= w_start_slot;
`else
        r_ar_addr   <= w_line_base;
        r_cnt       <= '0;
`endif
      end
      if (flush && (r_state == S_AR || r_state == S_RDATA || r_state == S_DRAIN))
        r_cancel <= 1'b1;
      if (w_beat) begin
        r_line[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= r_data;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_beat <= r_beat + CNT_W'(1);
        // Flag slave errors, an early r_last, or a missing r_last.
        if (r_resp[1] || (r_last != w_final)) r_err <= 1'b1;
      end
      if (w_set_done_err) r_done_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl. It uses directed scenarios and
// randomized bursts, and checks them against a transaction-level model of
// the refill rules. Honours ICACHE_REFILL_CRITICAL_WORD_FIRST_EN when defined.
module tb_icache_refill_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int LB    = 32;
  localparam int LW    = LB * 8;
  localparam int BEATS = LW / DW;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] EXP_BURST = 2'b10;
  localparam bit         CWF       = 1'b1;
`else
  localparam logic [1:0] EXP_BURST = 2'b01;
  localparam bit         CWF       = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          miss_req = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          miss_ready;
  logic          flush = 1'b0;
  logic          refill_valid;
  logic [AW-1:0] refill_addr;
  logic [LW-1:0] refill_data;
  logic          refill_err;
  logic          busy;
  logic          ar_valid;
  logic          ar_ready = 1'b0;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic [3:0]    ar_id;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [DW-1:0] r_data = '0;
  logic [1:0]    r_resp = '0;
  logic          r_last = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction configuration consumed by run_txn.
  logic [AW-1:0] t_addr;
  int            t_stall;
  bit            t_flush_ar;
  int            t_nbeats;
  int            t_flush_after;
  int            t_gap_pct;
  logic [DW-1:0] t_data [8];
  logic [1:0]    t_resp [8];

  // Observations from the last run_txn, for scenario-specific checks.
  int            g_ar_cyc;
  int            g_refill_cyc;
  logic [AW-1:0] g_ar_addr;
  logic [LW-1:0] g_line;

  icache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BYTES(LB), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .flush(flush),
    .refill_valid(refill_valid), .refill_addr(refill_addr),
    .refill_data(refill_data), .refill_err(refill_err), .busy(busy),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    miss_req = 1'b0;
    flush    = 1'b0;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_last   = 1'b0;
    r_resp   = 2'b00;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int beat_offset(input logic [AW-1:0] a);
    return CWF ? int'((a % LB) / (DW / 8)) : 0;
  endfunction

  // Runs one miss from acceptance until the controller is idle again.
  // Expected behaviour is derived from the transaction as a whole: which beats
  // go to which line slot, whether any error condition occurred, whether a
  // flush occurred, and when the refill pulse and idle must appear relative
  // to the r_last beat.
  task automatic run_txn(input string tag);
    int            cyc, beat, ar_cycles, refills, last_cyc, refill_cyc, idle_cyc, off;
    bit            ar_done, flush_sent, done, exp_err, got_err;
    logic [AW-1:0] exp_line_addr, exp_ar_addr, got_addr;
    logic [LW-1:0] exp_line, got_line;

    exp_line_addr = t_addr & ~AW'(LB - 1);
    exp_ar_addr   = CWF ? (t_addr & ~AW'(DW / 8 - 1)) : exp_line_addr;
    off           = beat_offset(t_addr);
    exp_err       = (t_nbeats != BEATS);
    for (int k = 0; k < t_nbeats; k++) if (t_resp[k][1]) exp_err = 1'b1;
    exp_line = '0;
    for (int k = 0; k < BEATS && k < t_nbeats; k++)
      exp_line[((off + k) % BEATS) * DW +: DW] = t_data[k];

    drive_idle();
    miss_req  = 1'b1;
    miss_addr = t_addr;
    #1;
    n_checks++;
    if (miss_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s accept: miss_ready=%b expected 1", tag, miss_ready);
    end
    @(posedge clk); #1;
    miss_req  = 1'b0;
    miss_addr = $urandom;

    cyc = 1; beat = 0; ar_cycles = 0; refills = 0; last_cyc = -1;
    refill_cyc = -1; idle_cyc = -1; ar_done = 0; flush_sent = 0; done = 0;
    got_err = 0; got_addr = '0; got_line = '0; g_ar_addr = '0; g_ar_cyc = -1;
    while (!done && cyc < 200) begin
      ar_ready = !ar_done && (ar_cycles >= t_stall);
      flush    = 1'b0;
      r_valid  = 1'b0;
      r_last   = 1'b0;
      r_resp   = 2'b00;
      r_data   = {$urandom, $urandom};
      if (!ar_done && t_flush_ar && ar_cycles == 0) begin
        flush = 1'b1; flush_sent = 1;
      end
      if (ar_done && beat < t_nbeats) begin
        if (t_flush_after >= 0 && beat == t_flush_after && !flush_sent) begin
          flush = 1'b1; flush_sent = 1;
        end else if ($urandom_range(99) >= t_gap_pct) begin
          r_valid = 1'b1;
          r_data  = t_data[beat];
          r_resp  = t_resp[beat];
          r_last  = (beat == t_nbeats - 1);
        end
      end
      #1;
      if (!ar_done) begin
        if (ar_cycles == 0) begin
          n_checks++;
          if ({ar_len, ar_size, ar_burst, ar_id} !== {8'(BEATS - 1), 3'd3, EXP_BURST, 4'd0}) begin
            n_errors++;
            $display("FAIL %s ar_fields: len=%0d size=%0d burst=%b id=%0d expected %0d 3 %b 0",
                     tag, ar_len, ar_size, ar_burst, ar_id, BEATS - 1, EXP_BURST);
          end
        end
        n_checks++;
        if (ar_valid !== 1'b1 || ar_addr !== exp_ar_addr) begin
          n_errors++;
          $display("FAIL %s ar_stable: ar_valid=%b ar_addr=%h expected 1 %h cyc=%0d",
                   tag, ar_valid, ar_addr, exp_ar_addr, cyc);
        end
        if (ar_ready) begin
          ar_done = 1; g_ar_cyc = cyc; g_ar_addr = ar_addr;
        end
        ar_cycles++;
      end
      if (r_valid) begin
        n_checks++;
        if (r_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL %s r_ready: r_ready=%b expected 1 beat=%0d", tag, r_ready, beat);
        end
        if (r_last) last_cyc = cyc;
        beat++;
      end
      if (refill_valid === 1'b1) begin
        refills++;
        refill_cyc = cyc;
        got_line   = refill_data;
        got_err    = refill_err;
        got_addr   = refill_addr;
      end
      if (ar_done && beat == t_nbeats && miss_ready === 1'b1) begin
        done = 1; idle_cyc = cyc;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    drive_idle();
    g_refill_cyc = refill_cyc;
    g_line       = got_line;

    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s timeout: beats=%0d of %0d ar_done=%0d", tag, beat, t_nbeats, ar_done);
    end
    if (flush_sent) begin
      n_checks++;
      if (refills != 0) begin
        n_errors++;
        $display("FAIL %s flushed_refill: pulses=%0d expected 0", tag, refills);
      end
      n_checks++;
      if (idle_cyc != last_cyc + 1) begin
        n_errors++;
        $display("FAIL %s flushed_idle: idle at %0d expected %0d", tag, idle_cyc, last_cyc + 1);
      end
    end else begin
      n_checks++;
      if (refills != 1 || refill_cyc != last_cyc + 1) begin
        n_errors++;
        $display("FAIL %s refill_pulse: pulses=%0d at %0d expected 1 at %0d",
                 tag, refills, refill_cyc, last_cyc + 1);
      end
      n_checks++;
      if (got_addr !== exp_line_addr || got_err !== exp_err) begin
        n_errors++;
        $display("FAIL %s refill_addr_err: addr=%h err=%b expected %h %b",
                 tag, got_addr, got_err, exp_line_addr, exp_err);
      end
      if (t_nbeats >= BEATS) begin
        n_checks++;
        if (got_line !== exp_line) begin
          n_errors++;
          $display("FAIL %s refill_data: got %h expected %h", tag, got_line, exp_line);
        end
      end
      n_checks++;
      if (idle_cyc != last_cyc + 2) begin
        n_errors++;
        $display("FAIL %s idle: idle at %0d expected %0d", tag, idle_cyc, last_cyc + 2);
      end
    end
  endtask

  task automatic clean_cfg(input logic [AW-1:0] addr);
    t_addr = addr; t_stall = 0; t_flush_ar = 0; t_nbeats = BEATS;
    t_flush_after = -1; t_gap_pct = 0;
    for (int k = 0; k < 8; k++) begin
      t_data[k] = {$urandom, $urandom};
      t_resp[k] = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    n_checks++;
    if ({miss_ready, busy, ar_valid, r_ready, refill_valid, refill_err} !== 6'b100000 ||
        refill_data !== '0 || refill_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b busy=%b arv=%b rr=%b rv=%b re=%b data=%h addr=%h",
               miss_ready, busy, ar_valid, r_ready, refill_valid, refill_err, refill_data, refill_addr);
    end
    rst = 1'b0;
    // Reset taken while an AR is still waiting for ar_ready.
    miss_req = 1'b1; miss_addr = 32'h1234_5678;
    @(posedge clk); #1;
    miss_req = 1'b0;
    n_checks++;
    if (ar_valid !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_pre: ar_valid=%b busy=%b expected 1 1", ar_valid, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (ar_valid !== 1'b0 || busy !== 1'b0 || miss_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid: ar_valid=%b busy=%b miss_ready=%b expected 0 0 1",
               ar_valid, busy, miss_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d [4];
    logic [LW-1:0] exp_line;
    int            off;
    do_reset();
    clean_cfg(32'h8000_1234);
    for (int k = 0; k < 4; k++) d[k] = {32'hD0D0_0000 + k, $urandom};
    off = beat_offset(t_addr);
    for (int k = 0; k < 4; k++) t_data[k] = d[(off + k) % 4];
    exp_line = {d[3], d[2], d[1], d[0]};
    run_txn("basic");
    n_checks++;
    if (g_ar_addr !== (CWF ? 32'h8000_1230 : 32'h8000_1220) || g_ar_cyc != 1) begin
      n_errors++;
      $display("FAIL basic_ar: addr=%h cyc=%0d expected %h 1", g_ar_addr, g_ar_cyc,
               CWF ? 32'h8000_1230 : 32'h8000_1220);
    end
    n_checks++;
    if (g_refill_cyc != 2 + BEATS || g_line !== exp_line) begin
      n_errors++;
      $display("FAIL basic_latency_data: cyc=%0d data=%h expected %0d %h",
               g_refill_cyc, g_line, 2 + BEATS, exp_line);
    end
  endtask

  // Beats are returned in wrap order starting at the missing beat, which is
  // the order a WRAP burst uses. In the default build the burst starts at
  // beat 0.
  task automatic test_critical_word();
    logic [DW-1:0] d [4];
    int            off;
    do_reset();
    clean_cfg(32'h8000_1230);
    for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
    off = beat_offset(t_addr);
    for (int k = 0; k < 4; k++) t_data[k] = d[(off + k) % 4];
    run_txn("critical_word");
    n_checks++;
    if (g_line !== {d[3], d[2], d[1], d[0]}) begin
      n_errors++;
      $display("FAIL critical_word_line: got %h expected %h", g_line, {d[3], d[2], d[1], d[0]});
    end
  endtask

  task automatic test_flush_ar();
    do_reset();
    clean_cfg($urandom);
    t_stall = 3; t_flush_ar = 1;
    run_txn("flush_ar");
  endtask

  task automatic test_back_to_back();
    do_reset();
    clean_cfg($urandom);
    t_flush_after = 1;
    run_txn("flush_rdata");
    clean_cfg($urandom);
    run_txn("after_flush");
    clean_cfg($urandom);
    run_txn("back_to_back");
  endtask

  task automatic test_errors();
    do_reset();
    clean_cfg($urandom);
    t_resp[2] = 2'b10;
    run_txn("slverr");
    clean_cfg($urandom);
    t_nbeats = 2;
    run_txn("early_last");
    clean_cfg($urandom);
    t_nbeats = 6;
    run_txn("missing_last");
  endtask

  task automatic test_miss_flush();
    do_reset();
    miss_req = 1'b1; flush = 1'b1; miss_addr = $urandom;
    @(posedge clk); #1;
    miss_req = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy !== 1'b0 || ar_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL miss_flush: busy=%b ar_valid=%b expected 0 0 cyc=%0d", busy, ar_valid, i);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      clean_cfg($urandom);
      t_stall   = $urandom_range(0, 3);
      t_gap_pct = $urandom_range(0, 50);
      if ($urandom_range(9) == 0) t_nbeats = $urandom_range(2, 6);
      for (int k = 0; k < 8; k++)
        t_resp[k] = ($urandom_range(9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      case ($urandom_range(6))
        0: t_flush_ar = 1;
        1: t_flush_after = $urandom_range(0, t_nbeats - 1);
        default: ;
      endcase
      run_txn($sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_critical_word();
    test_flush_ar();
    test_back_to_back();
    test_errors();
    test_miss_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
